// File: rtl/mc_ctrl_wait.sv
// mc_ctrl_wait: multi-cycle MIPS-lite control FSM with variable-latency memory.
//
// Sequences FETCH -> DCD -> EXE -> MA -> WB for the existing datapath. FETCH and MA
// hold a memory request until mem_ready. A wait counter escalates a stalled
// request to a sticky bus error. An undecoded instruction traps to HALT with a
// sticky ill_op flag. HALT is left only through reset.
//
// Handshake: mem_req is high for the whole of FETCH and of MA. The request
// completes in the cycle where mem_req and mem_ready are both high. The strobes
// tied to completion (PCWr/IRWr in FETCH, DMWr in MA) follow mem_ready in the same
// cycle, so they are single-cycle pulses.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   opeCode, funct           IR[31:26], IR[5:0]
//   zero, overflow           ALU flags (overflow sampled in EXE)
//   mem_ready                memory completes the current request this cycle
//   mem_req                  memory request active
//   PCWr, IRWr, DMWr, GPRWr  write enables
//   ALUsrc, ALUsign, byteOp  datapath selects
//   ALUop, ExtOp, NPCop, M2Rsel, GPRsel  2-bit datapath selects
//   bus_err, ill_op          sticky fault flags
//   state                    current FSM state (debug)
module mc_ctrl_wait #(
  parameter int   TO_W     = 4,
  parameter int   TO_MAX   = 15,
  parameter logic OVF_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opeCode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWr,
  output logic       IRWr,
  output logic       DMWr,
  output logic       GPRWr,
  output logic       ALUsrc,
  output logic       ALUsign,
  output logic       byteOp,
  output logic [1:0] ALUop,
  output logic [1:0] ExtOp,
  output logic [1:0] NPCop,
  output logic [1:0] M2Rsel,
  output logic [1:0] GPRsel,
  output logic       bus_err,
  output logic       ill_op,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DCD   = 3'd1,
    S_EXE   = 3'd2,
    S_MA    = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd7
  } state_t;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TO_MAX);

  state_t          state_q;
  logic [TO_W-1:0] cnt_q;
  logic            ovf_q;

  // Instruction decode from the IR fields
  logic r_type;
  logic is_addu, is_subu, is_slt, is_jr;
  logic is_ori, is_lw, is_lb, is_sw, is_sb, is_beq, is_lui, is_j, is_jal, is_addi, is_addiu;
  logic is_load, is_store, is_alu, is_legal;

  assign r_type   = (opeCode == 6'b000000);
  assign is_addu  = r_type & (funct == 6'b100001);
  assign is_subu  = r_type & (funct == 6'b100011);
  assign is_slt   = r_type & (funct == 6'b101010);
  assign is_jr    = r_type & (funct == 6'b001000);
  assign is_ori   = (opeCode == 6'b001101);
  assign is_lw    = (opeCode == 6'b100011);
  assign is_lb    = (opeCode == 6'b100000);
  assign is_sw    = (opeCode == 6'b101011);
  assign is_sb    = (opeCode == 6'b101000);
  assign is_beq   = (opeCode == 6'b000100);
  assign is_lui   = (opeCode == 6'b001111);
  assign is_j     = (opeCode == 6'b000010);
  assign is_jal   = (opeCode == 6'b000011);
  assign is_addi  = (opeCode == 6'b001000);
  assign is_addiu = (opeCode == 6'b001001);

  assign is_load  = is_lw | is_lb;
  assign is_store = is_sw | is_sb;
  assign is_alu   = is_addu | is_subu | is_slt | is_ori | is_lui | is_addi | is_addiu;
  assign is_legal = is_alu | is_load | is_store | is_beq | is_j | is_jal | is_jr;

  assign state = state_q;

  // State, wait counter, overflow capture and sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      bus_err <= 1'b0;
      ill_op  <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH, S_MA: begin
          if (mem_ready) begin
            // A completion on the TO_MAX cycle still counts as success
            cnt_q <= '0;
            if (state_q == S_FETCH) state_q <= S_DCD;
            else if (is_load)       state_q <= S_WB;
            else                    state_q <= S_FETCH;
          end else if (cnt_q == TO_LIM) begin
            cnt_q   <= '0;
            state_q <= S_HALT;
            bus_err <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DCD: begin
          cnt_q <= '0;
          if (!is_legal) begin
            state_q <= S_HALT;
            ill_op  <= 1'b1;
          end else if (is_jal) begin
            state_q <= S_WB;
          end else begin
            state_q <= S_EXE;
          end
        end
        S_EXE: begin
          cnt_q <= '0;
          ovf_q <= overflow & is_addi & OVF_TRAP;
          if (is_beq | is_j | is_jr) state_q <= S_FETCH;
          else if (is_alu)           state_q <= S_WB;
          else                       state_q <= S_MA;
        end
        S_WB: begin
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
          state_q <= S_FETCH;
        end
        S_HALT: begin
          cnt_q <= '0;
        end
        default: begin
          // Unused encodings park in HALT rather than run on garbage
          cnt_q   <= '0;
          state_q <= S_HALT;
        end
      endcase
    end
  end

  // Datapath controls: decoded from the current state, all zero unless listed
  always_comb begin
    mem_req = 1'b0;
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    DMWr    = 1'b0;
    GPRWr   = 1'b0;
    ALUsrc  = 1'b0;
    ALUsign = 1'b0;
    byteOp  = 1'b0;
    ALUop   = 2'b00;
    ExtOp   = 2'b00;
    NPCop   = 2'b00;
    M2Rsel  = 2'b00;
    GPRsel  = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        PCWr    = mem_ready;
        IRWr    = mem_ready;
      end
      S_DCD: begin
        ExtOp = {is_lui, is_load | is_store | is_addi};
      end
      S_EXE: begin
        ALUsrc  = is_ori | is_load | is_store | is_lui | is_addi | is_addiu;
        ALUop   = {is_ori | is_slt, is_subu | is_beq | is_slt};
        ALUsign = is_addi | is_slt;
        NPCop   = {is_j | is_jal | is_jr, is_beq | is_jr};
        PCWr    = is_j | is_jr | (is_beq & zero);
      end
      S_MA: begin
        mem_req = 1'b1;
        byteOp  = is_lb | is_sb;
        DMWr    = is_store & mem_ready;
      end
      S_WB: begin
        GPRWr = 1'b1;
        PCWr  = is_jal;
        NPCop = is_jal ? 2'b10 : 2'b00;
        if (ovf_q) begin
          // Overflowing addi writes 1 to $30
          M2Rsel = 2'b11;
          GPRsel = 2'b11;
        end else begin
          M2Rsel = {is_jal, is_load};
          GPRsel = {is_jal, is_ori | is_load | is_lui | is_addi | is_addiu};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mc_ctrl_wait.md
Name: mc_ctrl_wait

Overview:
- Next-generation multi-cycle MIPS-lite control FSM: FETCH, DCD, EXE, MA and WB sequencing for the existing datapath, plus variable-latency memory.
- Fetch and data access wait on a `mem_ready` handshake, with a parametrised timeout to a sticky bus-error state.
- Adds illegal-opcode trapping and an optional overflow write-back to $30.
- Sits between the IR decode fields and the datapath enables (PC, IR, GPR, DM, ALU, NPC, EXT).

Parameters:
- TO_W, 4: width of the wait-state counter.
- TO_MAX, 15: wait cycles tolerated in FETCH/MA before the bus error; must be < 2^TO_W.
- OVF_TRAP, 1: 1 = an `addi` overflow writes 1 to $30 instead of rt; 0 = normal rt write.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- opeCode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- overflow  in  1  ALU signed overflow, valid in EXE
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request active (FETCH, or MA for load/store)
- PCWr, IRWr, DMWr, GPRWr  out  1 each  write enables
- ALUsrc, ALUsign, byteOp  out  1 each  datapath selects
- ALUop, ExtOp, NPCop, M2Rsel, GPRsel  out  2 each  datapath selects (encodings unchanged from the current controller)
- bus_err  out  1  sticky timeout flag
- ill_op  out  1  sticky illegal-instruction flag
- state  out  3  current state, for debug

Behaviour:
- **Reset.** `rst`=0 asynchronously forces:
  - state=FETCH, wait counter=0, ovf_q=0;
  - bus_err=0, ill_op=0.
  - Reset mid-MA aborts the access; DMWr drops immediately.
- **Decoded set.** addu, subu, slt, jr, ori, lw, lb, sw, sb, beq, lui, j, jal, addi, addiu. Anything else is illegal.
- **Output defaults.** Every output is 0 in every state unless listed below. No latched selects.
- **State encoding.** FETCH=0, DCD=1, EXE=2, MA=3, WB=4, HALT=7.
- **FETCH**
  - mem_req=1.
  - If mem_ready=1: PCWr=1, IRWr=1, NPCop=00, next state DCD.
  - Otherwise stay in FETCH, counter+1.
- **DCD**
  - ExtOp[0]=lw|lb|sw|sb|addi; ExtOp[1]=lui.
  - Next state:
    - illegal: HALT, ill_op set;
    - jal: WB;
    - else: EXE.
- **EXE**
  - ALUsrc = ori|lw|lb|sw|sb|lui|addi|addiu.
  - ALUop[0] = subu|beq|slt; ALUop[1] = ori|slt; ALUsign = addi|slt.
  - NPCop[0] = beq|jr; NPCop[1] = j|jal|jr.
  - PCWr = j|jr|(beq&zero). beq not taken gives PCWr=0.
  - ovf_q <= overflow & addi & OVF_TRAP.
  - Next state:
    - beq|j|jr: FETCH;
    - ALU ops: WB;
    - loads/stores: MA.
- **MA**
  - mem_req=1; byteOp = lb|sb; DMWr = (sw|sb) & mem_ready, a single-cycle strobe.
  - If mem_ready=1: next state WB for lw|lb, FETCH for stores.
  - Otherwise stay in MA, counter+1.
- **WB**
  - GPRWr=1; PCWr=jal; NPCop=10 for jal.
  - M2Rsel[0] = lw|lb|ovf_q; M2Rsel[1] = jal|ovf_q.
  - GPRsel[0] = ori|lw|lb|lui|addi|addiu (when ovf_q=0); GPRsel[1] = jal|ovf_q.
  - ovf_q=1 forces M2Rsel=11 and GPRsel=11.
  - Next state FETCH; ovf_q cleared.
- **Wait counter**
  - Cleared on every state change.
  - Increments each cycle spent in FETCH or MA with mem_ready=0.
  - Counter==TO_MAX with mem_ready=0: next state HALT, bus_err set.
  - mem_ready=1 on the TO_MAX cycle counts as success.
- **HALT**
  - All enables 0, mem_req=0.
  - Held until reset; bus_err and ill_op stay at their values.
- Zero-wait memory (mem_ready tied to 1) gives the legacy cycle counts:

  | Class | Cycles |
  |---|---|
  | R-type / I-type ALU | 4 |
  | lw | 5 |
  | sw | 4 |
  | beq / j / jr | 3 |
  | jal | 3 |

- No `$display` in RTL.

Test Plan:
1. addu, mem_ready=1 constantly → states 0,1,2,4,0. GPRWr=1 only in cycle 4 with GPRsel=00, M2Rsel=00. PCWr=1 only in the FETCH cycle.
2. lw, mem_ready low for 3 cycles in FETCH and 2 in MA → FETCH lasts 4 cycles, MA lasts 3, IRWr is a one-cycle pulse. WB has M2Rsel=01, GPRsel=01. Total 10 cycles.
3. sw with mem_ready never asserted in MA, TO_MAX=15 → after 16 MA cycles state=7, bus_err=1, DMWr never 1. Pulse `rst` → FETCH, bus_err=0.
4. beq, zero=0 then zero=1 → PCWr=0 / 1 in EXE, NPCop=01. jal → DCD→WB, PCWr=1, GPRsel=10, M2Rsel=10.
5. addi with overflow=1 in EXE, OVF_TRAP=1 → WB GPRsel=11, M2Rsel=11, GPRWr=1. Same with OVF_TRAP=0 → GPRsel=01, M2Rsel=00.
6. opeCode=6'b111111 → DCD→HALT, ill_op=1, no further PCWr/IRWr. Reset asserted mid-MA of sb → DMWr=0 immediately, state=0.
